// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for the EX stage: {remainder, quotient} for
// signed or unsigned operands, with stall request, annul and div-by-zero handling.
//   state  | meaning
//   IDLE   | waiting for an accepted start (start high, annul low)
//   BYZERO | divisor was zero; produce a zero result next edge
//   ON     | one shift-subtract step per edge until the counter reaches WIDTH
//   END    | result valid; held until start drops
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 signed_div_input,
  input  logic [WIDTH-1:0]     opdata1_input,
  input  logic [WIDTH-1:0]     opdata2_input,
  input  logic                 start_input,
  input  logic                 annul_input,
  output logic [2*WIDTH-1:0]   result_output,
  output logic                 ready_output,
  output logic                 stall_request_output
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  localparam logic [5:0] CNT_LAST = 6'(WIDTH);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q;
  logic [WIDTH-1:0] quo_q, dsr_q, rem_q;
  logic             sign_a_q, sign_b_q, signed_q;
  logic [2*WIDTH-1:0] result_q;
  logic             ready_q;

  logic             accept, step;
  logic [WIDTH-1:0] abs1, abs2, q_fix, r_fix;
  logic [WIDTH:0]   trial, diff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_input && !annul_input) begin
          accept  = 1'b1;
          state_d = (opdata2_input == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: state_d = annul_input ? S_IDLE : S_END;
      S_ON: begin
        if (annul_input)              state_d = S_IDLE;
        else if (cnt_q == CNT_LAST)   state_d = S_END;
        else                          step    = 1'b1;
      end
      S_END: if (!start_input) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    abs1  = (signed_div_input && opdata1_input[WIDTH-1]) ? -opdata1_input : opdata1_input;
    abs2  = (signed_div_input && opdata2_input[WIDTH-1]) ? -opdata2_input : opdata2_input;
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dsr_q};
    // Quotient sign follows the XOR of operand signs; remainder follows the dividend.
    q_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    r_fix = (signed_q && sign_a_q) ? -rem_q : rem_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      signed_q <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      quo_q    <= abs1;
      dsr_q    <= abs2;
      rem_q    <= '0;
      sign_a_q <= opdata1_input[WIDTH-1];
      sign_b_q <= opdata2_input[WIDTH-1];
      signed_q <= signed_div_input;
    end else if (step) begin
      cnt_q <= cnt_q + 6'd1;
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == S_END);
      if (state_d != S_END)
        result_q <= '0;
      else if (state_q == S_ON)
        result_q <= {r_fix, q_fix};
      else if (state_q == S_BYZERO)
        result_q <= '0;
    end
  end

  assign result_output        = result_q;
  assign ready_output         = ready_q;
  assign stall_request_output = start_input & ~ready_q;

endmodule
